// File: rtl/tpu_pkg.sv
// Shared types, defaults and helpers for the TPU operand feeder.
package tpu_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_BITS_C  = 16;
  localparam int unsigned DEF_DIM     = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } feeder_state_t;

  // FEED cycles until the last product reaches the far corner cell.
  function automatic int unsigned feed_len(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_operand_feeder_if.sv
// Write/start bus and MAC-array drive signals of the operand feeder.
interface tpu_operand_feeder_if #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter int unsigned DIM     = 8
);
  localparam int unsigned IdxW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                   wr_en;
  logic                   wr_sel;
  logic [IdxW-1:0]        wr_idx;
  logic [DIM*BITS_AB-1:0] wr_data;
  logic                   start;

  logic [DIM*BITS_AB-1:0] a_out;
  logic [DIM*BITS_AB-1:0] b_out;
  logic [BITS_C-1:0]      c_out;
  logic                   mac_en;
  logic                   mac_wren;
  logic                   busy;
  logic                   done;

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start,
    input  a_out, b_out, c_out, mac_en, mac_wren, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start,
    output a_out, b_out, c_out, mac_en, mac_wren, busy, done
  );

endinterface

// File: rtl/feeder_matrix_buf.sv
// DIM x DIM operand register file with a vector write port and a skewed diagonal read.
module feeder_matrix_buf #(
  parameter  int unsigned BITS_AB = 8,
  parameter  int unsigned DIM     = 8,
  parameter  int unsigned TW      = 5,
  localparam int unsigned IdxW    = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [IdxW-1:0]        i_wr_idx,
  input  logic [DIM*BITS_AB-1:0] i_wr_data,
  input  logic [TW-1:0]          i_t,
  output logic [DIM*BITS_AB-1:0] o_diag
);

  // Entry i holds row i of A (row mode) or column i of B (column mode); element k is the
  // K index in both cases, so one diagonal read serves either orientation.
  logic [DIM*BITS_AB-1:0] r_mem [DIM];
  int                     w_k;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Lane i presents element k = t - i, zero outside the valid K range.
  always_comb begin
    o_diag = '0;
    w_k    = 0;
    for (int i = 0; i < int'(DIM); i++) begin
      w_k = int'(i_t) - i;
      if (w_k >= 0 && w_k < int'(DIM)) begin
        o_diag[i*BITS_AB +: BITS_AB] = r_mem[i][w_k*BITS_AB +: BITS_AB];
      end
    end
  end

endmodule

// File: rtl/tpu_operand_feeder.sv
// Operand feeder for the systolic tpumac array: buffers A/B and streams skewed operands.
// Optional TPU_FEEDER_CLEAR_EN adds a one-cycle accumulator clear before each run.
module tpu_operand_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned BITS_C  = DEF_BITS_C,
  parameter int unsigned DIM     = DEF_DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  tpu_operand_feeder_if.slave bus
);

  localparam int unsigned FeedLen = feed_len(DIM);
  localparam int unsigned TW      = $clog2(FeedLen);

  feeder_state_t          r_state;
  feeder_state_t          w_state_d;
  logic [TW-1:0]          r_t;
  logic [TW-1:0]          w_t_d;
  logic                   w_wr_ok;
  logic                   w_wr_a;
  logic                   w_wr_b;
  logic [DIM*BITS_AB-1:0] w_a_diag;
  logic [DIM*BITS_AB-1:0] w_b_diag;

  // Buffers are only writable while idle so a running product sees stable operands.
  assign w_wr_ok = bus.wr_en && (r_state == IDLE);
  assign w_wr_a  = w_wr_ok && !bus.wr_sel;
  assign w_wr_b  = w_wr_ok && bus.wr_sel;

  feeder_matrix_buf #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .TW      (TW)
  ) u_a_buf (
    .i_clk     (clk),
    .i_wr_en   (w_wr_a),
    .i_wr_idx  (bus.wr_idx),
    .i_wr_data (bus.wr_data),
    .i_t       (r_t),
    .o_diag    (w_a_diag)
  );

  feeder_matrix_buf #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .TW      (TW)
  ) u_b_buf (
    .i_clk     (clk),
    .i_wr_en   (w_wr_b),
    .i_wr_idx  (bus.wr_idx),
    .i_wr_data (bus.wr_data),
    .i_t       (r_t),
    .o_diag    (w_b_diag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_d;
      r_t     <= w_t_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_t_d     = r_t;
    unique case (r_state)
      IDLE: begin
        w_t_d = '0;
        if (bus.start) begin
`ifdef TPU_FEEDER_CLEAR_EN
          w_state_d = CLEAR;
`else
          w_state_d = FEED;
`endif
        end
      end
      CLEAR: begin
        w_state_d = FEED;
        w_t_d     = '0;
      end
      FEED: begin
        if (r_t == TW'(FeedLen - 1)) begin
          w_state_d = DONE;
          w_t_d     = '0;
        end else begin
          w_t_d = r_t + TW'(1);
        end
      end
      DONE: begin
        w_state_d = IDLE;
        w_t_d     = '0;
      end
      default: begin
        w_state_d = IDLE;
        w_t_d     = '0;
      end
    endcase
  end

  // Outputs decode only flops (state, t, buffers), so they move solely on rising clk.
  always_comb begin
    bus.a_out    = '0;
    bus.b_out    = '0;
    bus.c_out    = '0;
    bus.mac_en   = 1'b0;
    bus.mac_wren = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (r_state)
      IDLE: begin
      end
      CLEAR: begin
        bus.mac_en = 1'b1;
`ifdef TPU_FEEDER_CLEAR_EN
        bus.mac_wren = 1'b1;
`endif
        bus.busy   = 1'b1;
      end
      FEED: begin
        bus.mac_en = 1'b1;
        bus.busy   = 1'b1;
        bus.a_out  = w_a_diag;
        bus.b_out  = w_b_diag;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Completion is a single-cycle pulse and never overlaps MAC activity.
  assert property (@(posedge clk) disable iff (!rst_n) bus.done |=> !bus.done);
  assert property (@(posedge clk) disable iff (!rst_n) bus.done |-> !bus.mac_en);

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Randomized bench for tpu_operand_feeder with a behavioural MAC-grid model.
// Expectations follow TPU_FEEDER_CLEAR_EN when it is defined for the build.
module tb_tpu_operand_feeder;

  localparam int unsigned BITS_AB = 8;
  localparam int unsigned BITS_C  = 16;
  localparam int unsigned DIM     = 4;
  localparam int unsigned IdxW    = $clog2(DIM);
  localparam int          FeedLen = 3 * DIM - 2;
  localparam int unsigned VW      = DIM * BITS_AB;

  logic clk;
  logic rst_n;

  tpu_operand_feeder_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) bus ();

  tpu_operand_feeder #(
    .BITS_AB (BITS_AB),
    .BITS_C  (BITS_C),
    .DIM     (DIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int wren_cnt = 0;
  int n_started = 0;

  logic signed [BITS_AB-1:0] ma [DIM][DIM];  // A[r][k]
  logic signed [BITS_AB-1:0] mb [DIM][DIM];  // B[k][c]
  logic [BITS_C-1:0]         exp_acc [DIM][DIM];

  // Behavioural grid of tpumac cells driven by the DUT outputs.
  logic signed [BITS_AB-1:0] cap [DIM][DIM];
  logic signed [BITS_AB-1:0] cbp [DIM][DIM];
  logic [BITS_C-1:0]         cacc [DIM][DIM];

  function automatic logic signed [BITS_AB-1:0] cell_a(input int r, input int c);
    if (c == 0) return bus.a_out[r*BITS_AB +: BITS_AB];
    return cap[r][c-1];
  endfunction

  function automatic logic signed [BITS_AB-1:0] cell_b(input int r, input int c);
    if (r == 0) return bus.b_out[c*BITS_AB +: BITS_AB];
    return cbp[r-1][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          cap[r][c]  <= '0;
          cbp[r][c]  <= '0;
          cacc[r][c] <= '0;
        end
      end
    end else if (bus.mac_en) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          cap[r][c]  <= cell_a(r, c);
          cbp[r][c]  <= cell_b(r, c);
          cacc[r][c] <= bus.mac_wren ? bus.c_out
                      : cacc[r][c] + BITS_C'(int'(cell_a(r, c)) * int'(cell_b(r, c)));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.mac_wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.a_out, bus.b_out, bus.c_out, bus.mac_en, bus.mac_wren, bus.busy, bus.done});
  endfunction

  function automatic logic [127:0] pack_exp(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic en, input logic wren,
                                            input logic busy, input logic done);
    return 128'({a, b, BITS_C'(0), en, wren, busy, done});
  endfunction

  // Row r carries A[r][t-r]; column c carries B[t-c][c].
  function automatic logic [VW-1:0] exp_a(input int t);
    logic [VW-1:0] v = '0;
    for (int r = 0; r < DIM; r++)
      if (t - r >= 0 && t - r < DIM) v[r*BITS_AB +: BITS_AB] = ma[r][t-r];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_b(input int t);
    logic [VW-1:0] v = '0;
    for (int c = 0; c < DIM; c++)
      if (t - c >= 0 && t - c < DIM) v[c*BITS_AB +: BITS_AB] = mb[t-c][c];
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < DIM; k++) v[k*BITS_AB +: BITS_AB] = BITS_AB'($urandom);
    return v;
  endfunction

  task automatic model_write(input logic sel, input int idx, input logic [VW-1:0] d);
    for (int k = 0; k < DIM; k++) begin
      if (!sel) ma[idx][k] = d[k*BITS_AB +: BITS_AB];
      else      mb[k][idx] = d[k*BITS_AB +: BITS_AB];
    end
  endtask

  task automatic load_all();
    logic [VW-1:0] v;
    for (int i = 0; i < 2 * DIM; i++) begin
      for (int k = 0; k < DIM; k++)
        v[k*BITS_AB +: BITS_AB] = (i < DIM) ? ma[i][k] : mb[k][i-DIM];
      bus.wr_en   = 1'b1;
      bus.wr_sel  = (i >= DIM);
      bus.wr_idx  = IdxW'(i % DIM);
      bus.wr_data = v;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  // One product run, checked cycle by cycle from the start pulse; rst_t >= 0 resets mid-FEED.
  task automatic do_run(input bit wr_busy, input bit start_busy, input bit wr_start,
                        input int rst_t);
    int d0;
    int sum;
    logic [VW-1:0] v;
    logic sel;
    int idx;
    d0 = done_cnt;
    if (wr_start) begin
      sel = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, DIM - 1));
      v   = rand_vec();
      bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_idx = IdxW'(idx); bus.wr_data = v;
      model_write(sel, idx, v);
    end
    bus.start = 1'b1;
    n_started++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
`ifdef TPU_FEEDER_CLEAR_EN
    check_eq("clear", outs(), pack_exp('0, '0, 1'b1, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
`endif
    for (int t = 0; t < FeedLen; t++) begin
      check_eq($sformatf("feed_t%0d", t), outs(),
               pack_exp(exp_a(t), exp_b(t), 1'b1, 1'b0, 1'b1, 1'b0));
      if (t == rst_t) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", outs(), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++) exp_acc[r][c] = '0;
        repeat (3) begin
          @(negedge clk);
          check_eq("rst_idle", outs(), 128'(0));
        end
        return;
      end
      if (wr_busy && t == 2) begin
        bus.wr_en  = 1'b1;
        bus.wr_sel = 1'($urandom_range(0, 1));
        bus.wr_idx = IdxW'($urandom_range(0, DIM - 1));
        bus.wr_data = rand_vec();
      end
      if (start_busy && t == 4) bus.start = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
    end
    check_eq("done", outs(), pack_exp('0, '0, 1'b0, 1'b0, 1'b1, 1'b1));
    if (start_busy) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("idle", outs(), 128'(0));
    check_eq("done_cnt", 128'(done_cnt - d0), 128'(1));
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        sum = 0;
        for (int k = 0; k < DIM; k++) sum += int'(ma[r][k]) * int'(mb[k][c]);
`ifdef TPU_FEEDER_CLEAR_EN
        exp_acc[r][c] = BITS_C'(sum);
`else
        exp_acc[r][c] = exp_acc[r][c] + BITS_C'(sum);
`endif
        check_eq($sformatf("cell_%0d_%0d", r, c), 128'(cacc[r][c]), 128'(exp_acc[r][c]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.start = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) exp_acc[r][c] = '0;
    repeat (2) @(negedge clk);
    check_eq("reset", outs(), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset", outs(), 128'(0));

    // Skew pattern: A[r][k]=16r+k, B[k][c]=16k+c.
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = BITS_AB'(16 * r + k);
        mb[r][k] = BITS_AB'(16 * r + k);
      end
    load_all();
    do_run(1'b0, 1'b0, 1'b0, -1);

    // Identity A, B[k][c]=k-c (negative results), run twice on the same data.
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = (r == k) ? BITS_AB'(1) : BITS_AB'(0);
        mb[r][k] = BITS_AB'(r - k);
      end
    load_all();
    do_run(1'b0, 1'b0, 1'b0, -1);
    do_run(1'b0, 1'b0, 1'b0, -1);

    // Random operands with protocol abuse during busy and a write alongside start.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < DIM; r++)
        for (int k = 0; k < DIM; k++) begin
          ma[r][k] = BITS_AB'($urandom);
          mb[r][k] = BITS_AB'($urandom);
        end
      load_all();
      do_run(1'b1, 1'b1, i[0], -1);
    end

    // All -128: sums wrap in the accumulator, feeder passes operands untouched.
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = 8'sh80;
        mb[r][k] = 8'sh80;
      end
    load_all();
    do_run(1'b0, 1'b0, 1'b0, -1);

    // Reset in the middle of FEED, then a fresh run.
    do_run(1'b0, 1'b0, 1'b0, 5);
    do_run(1'b0, 1'b0, 1'b0, -1);

`ifdef TPU_FEEDER_CLEAR_EN
    check_eq("wren_cycles", 128'(wren_cnt), 128'(n_started));
`else
    check_eq("wren_cycles", 128'(wren_cnt), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
